rx_link_controller: RTL and testbench
=====================================

// Module: rx_link_controller
// PURPOSE
// Sequences the receiver datapath (sincronizador -> k285Detector -> serialParalelo -> decoder -> from8bit).
// Acquires symbol lock from K28.5 comma detections, then drives the read enable of the deserialiser/decoder/expander.
// Monitors decoder errors and comma spacing while locked; drops lock and restarts the search when the link degrades.
// Sits beside recibidor; its lectura_enb replaces the k285Detector lectura output as the datapath enable.
// PARAMETERS
// LOCK_COMMAS    4   consecutive in-time commas required to declare lock (>=1)
// COMMA_TIMEOUT  64  max symbols between commas before lock/alignment is abandoned
// ERR_THRESH     4   decoder errors inside one window that force loss of lock (>=1)
// ERR_WINDOW     16  symbols per error-counting window
// CNT_W          8   width of internal symbol/comma counters; must hold COMMA_TIMEOUT and ERR_WINDOW
// PORTS
// clk            in   1   receiver bit clock (clkRx domain)
// rst            in   1   asynchronous reset, active-low
// enb            in   1   block enable; 0 forces IDLE
// sym_strobe     in   1   one-cycle pulse per 10-bit symbol boundary (clk10 edge, synchronous to clk)
// esk285         in   1   comma detected, one-cycle pulse from k285Detector
// error_probable in   1   decoder invalid-symbol flag, sampled only on sym_strobe
// lectura_enb    out  1   datapath enable to serialParalelo/decoder/from8bit
// link_up        out  1   1 while in LOCKED
// lock_lost      out  1   one-cycle pulse on LOCKED -> SEARCH
// state          out  2   00 IDLE, 01 SEARCH, 10 ALIGN, 11 LOCKED
// err_total      out  8   saturating count of errors seen in LOCKED since reset
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; all counters, lectura_enb, link_up, lock_lost, err_total = 0.
// - All outputs registered; state transition visible one clk after the causing input is sampled.
// - enb=0 in any state: next cycle IDLE, comma/symbol/window/error counters cleared; err_total held.
// - IDLE: outputs 0. enb=1 -> SEARCH.
// - SEARCH: lectura_enb=0. esk285=1 -> ALIGN with comma_cnt=1, gap_cnt=0.
// - ALIGN: lectura_enb=1. sym_strobe increments gap_cnt; esk285 resets gap_cnt=0 and increments comma_cnt.
//   comma_cnt reaching LOCK_COMMAS -> LOCKED (win_cnt=0, err_cnt=0).
//   gap_cnt reaching COMMA_TIMEOUT, or error_probable=1 on sym_strobe -> SEARCH.
//   esk285 and timeout on the same cycle: comma wins (stay/advance).
// - LOCKED: lectura_enb=1, link_up=1. Each sym_strobe increments win_cnt and gap_cnt.
//   error_probable on sym_strobe: err_cnt+1, err_total+1 (saturates at 255).
//   win_cnt reaching ERR_WINDOW: win_cnt=0, err_cnt=0, or err_cnt=1 if an error arrives on that same strobe.
//   err_cnt reaching ERR_THRESH, or gap_cnt reaching COMMA_TIMEOUT -> SEARCH, lock_lost=1 for one cycle,
//   link_up=0 and lectura_enb=0 in that same registered update.
//   Threshold check wins over window wrap on the same strobe.
// - LOCK_COMMAS=1: first comma in SEARCH goes straight to ALIGN, then to LOCKED on the next cycle.
// - esk285 without sym_strobe is still honoured; error_probable without sym_strobe is ignored.
// - Counters never wrap; they stop at their terminal value until the state changes.
// TESTING
// 1) rst=0 mid-LOCKED -> all outputs 0, state=00 asynchronously; release with enb=1 -> state=01 next clk.
// 2) enb=1, 4 commas spaced 10 symbols, no errors -> state 01->10->11, link_up=1 after 4th esk285 +1 clk.
// 3) In ALIGN after 2 commas, no comma for 64 strobes -> state=01, lectura_enb=0; comma_cnt restarts at 1.
// 4) LOCKED, 4 errors within 16 symbols -> lock_lost single pulse, state=01, err_total=4.
// 5) LOCKED, 3 errors per 16-symbol window repeated 5 windows -> stays LOCKED, err_total=15; error on wrap strobe counts 1.
// 6) enb dropped in LOCKED -> state=00 next clk, link_up=0, err_total unchanged; re-enable relocks per test 2.

Source files
------------

// File: rtl/rx_link_controller.sv
// Receiver link sequencer: acquires K28.5 symbol lock, drives the datapath read enable,
// and drops back to search when commas go missing or decoder errors pile up.
module rx_link_controller #(
  parameter int LOCK_COMMAS   = 4,
  parameter int COMMA_TIMEOUT = 64,
  parameter int ERR_THRESH    = 4,
  parameter int ERR_WINDOW    = 16,
  parameter int CNT_W         = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enb,
  input  logic       i_sym_strobe,
  input  logic       i_esk285,
  input  logic       i_error_probable,
  output logic       o_lectura_enb,
  output logic       o_link_up,
  output logic       o_lock_lost,
  output logic [1:0] o_state,
  output logic [7:0] o_err_total
);

  typedef enum logic [1:0] {IDLE = 2'b00, SEARCH = 2'b01, ALIGN = 2'b10, LOCKED = 2'b11} state_t;

  localparam logic [CNT_W-1:0] LP_LOCK    = CNT_W'(LOCK_COMMAS);
  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(COMMA_TIMEOUT);
  localparam logic [CNT_W-1:0] LP_THRESH  = CNT_W'(ERR_THRESH);
  localparam logic [CNT_W-1:0] LP_WINDOW  = CNT_W'(ERR_WINDOW);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_comma_cnt, r_gap_cnt, r_win_cnt, r_err_cnt;
  logic [CNT_W-1:0] w_comma_nxt, w_gap_nxt, w_win_nxt, w_err_nxt;
  logic [CNT_W-1:0] w_comma_inc, w_gap_inc, w_win_inc, w_err_inc;
  logic [CNT_W-1:0] w_err_acc, w_gap_acc;
  logic [7:0]       r_err_total, w_err_total_nxt;
  logic             r_lectura_enb, r_link_up, r_lock_lost, w_lock_lost_nxt;
  logic             w_err_hit;

  // Counters hold at all-ones rather than wrapping back to zero.
  assign w_comma_inc = (&r_comma_cnt) ? r_comma_cnt : r_comma_cnt + 1'b1;
  assign w_gap_inc   = (&r_gap_cnt)   ? r_gap_cnt   : r_gap_cnt + 1'b1;
  assign w_win_inc   = (&r_win_cnt)   ? r_win_cnt   : r_win_cnt + 1'b1;
  assign w_err_inc   = (&r_err_cnt)   ? r_err_cnt   : r_err_cnt + 1'b1;
  assign w_err_hit   = i_sym_strobe & i_error_probable;
  assign w_err_acc   = w_err_hit ? w_err_inc : r_err_cnt;
  assign w_gap_acc   = i_esk285 ? '0 : (i_sym_strobe ? w_gap_inc : r_gap_cnt);

  always_comb begin
    w_state_nxt     = r_state;
    w_comma_nxt     = r_comma_cnt;
    w_gap_nxt       = r_gap_cnt;
    w_win_nxt       = r_win_cnt;
    w_err_nxt       = r_err_cnt;
    w_err_total_nxt = r_err_total;
    w_lock_lost_nxt = 1'b0;
    if (!i_enb) begin
      w_state_nxt = IDLE;
      w_comma_nxt = '0;
      w_gap_nxt   = '0;
      w_win_nxt   = '0;
      w_err_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = SEARCH;
          w_comma_nxt = '0;
          w_gap_nxt   = '0;
          w_win_nxt   = '0;
          w_err_nxt   = '0;
        end
        SEARCH: begin
          if (i_esk285) begin
            w_state_nxt = ALIGN;
            w_comma_nxt = CNT_W'(1);
            w_gap_nxt   = '0;
          end
        end
        ALIGN: begin
          if (w_err_hit) begin
            w_state_nxt = SEARCH;
            w_comma_nxt = '0;
            w_gap_nxt   = '0;
          end else if (r_comma_cnt >= LP_LOCK) begin
            w_state_nxt = LOCKED;
            w_gap_nxt   = '0;
            w_win_nxt   = '0;
            w_err_nxt   = '0;
          end else if (i_esk285) begin
            // A comma beats a timeout landing on the same cycle.
            w_comma_nxt = w_comma_inc;
            w_gap_nxt   = '0;
            if (w_comma_inc >= LP_LOCK) begin
              w_state_nxt = LOCKED;
              w_win_nxt   = '0;
              w_err_nxt   = '0;
            end
          end else if (i_sym_strobe) begin
            w_gap_nxt = w_gap_inc;
            if (w_gap_inc >= LP_TIMEOUT) begin
              w_state_nxt = SEARCH;
              w_comma_nxt = '0;
              w_gap_nxt   = '0;
            end
          end
        end
        LOCKED: begin
          if (w_err_hit && r_err_total != 8'hFF) w_err_total_nxt = r_err_total + 8'd1;
          // Threshold is evaluated before the window wrap so the wrap strobe's error still counts.
          if (w_err_acc >= LP_THRESH || w_gap_acc >= LP_TIMEOUT) begin
            w_state_nxt     = SEARCH;
            w_lock_lost_nxt = 1'b1;
            w_comma_nxt     = '0;
            w_gap_nxt       = '0;
            w_win_nxt       = '0;
            w_err_nxt       = '0;
          end else begin
            w_gap_nxt = w_gap_acc;
            if (i_sym_strobe && w_win_inc >= LP_WINDOW) begin
              w_win_nxt = '0;
              w_err_nxt = w_err_hit ? CNT_W'(1) : '0;
            end else begin
              w_win_nxt = i_sym_strobe ? w_win_inc : r_win_cnt;
              w_err_nxt = w_err_acc;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= IDLE;
      r_comma_cnt   <= '0;
      r_gap_cnt     <= '0;
      r_win_cnt     <= '0;
      r_err_cnt     <= '0;
      r_err_total   <= '0;
      r_lectura_enb <= 1'b0;
      r_link_up     <= 1'b0;
      r_lock_lost   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_comma_cnt   <= w_comma_nxt;
      r_gap_cnt     <= w_gap_nxt;
      r_win_cnt     <= w_win_nxt;
      r_err_cnt     <= w_err_nxt;
      r_err_total   <= w_err_total_nxt;
      r_lectura_enb <= (w_state_nxt == ALIGN) || (w_state_nxt == LOCKED);
      r_link_up     <= (w_state_nxt == LOCKED);
      r_lock_lost   <= w_lock_lost_nxt;
    end
  end

  assign o_state       = r_state;
  assign o_lectura_enb = r_lectura_enb;
  assign o_link_up     = r_link_up;
  assign o_lock_lost   = r_lock_lost;
  assign o_err_total   = r_err_total;

endmodule

// File: tb/tb_rx_link_controller.sv
// Directed bench for rx_link_controller with hand-computed expectations.
module tb_rx_link_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b0;
  logic       sym = 1'b0;
  logic       esk = 1'b0;
  logic       err = 1'b0;
  logic       lect, lup, llost;
  logic [1:0] st;
  logic [7:0] etot;
  int         n_checks = 0;
  int         n_errors = 0;

  rx_link_controller dut (
    .i_clk(clk), .i_rst(rst), .i_enb(enb), .i_sym_strobe(sym), .i_esk285(esk),
    .i_error_probable(err), .o_lectura_enb(lect), .o_link_up(lup), .o_lock_lost(llost),
    .o_state(st), .o_err_total(etot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs sampled 1 time unit after the edge.
  task automatic cyc(input logic s, input logic k, input logic e);
    sym = s; esk = k; err = e;
    @(posedge clk); #1;
    sym = 1'b0; esk = 1'b0; err = 1'b0;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  // From SEARCH: four commas, each after 9 clean symbols.
  task automatic do_lock(input string tag);
    cyc(1'b0, 1'b1, 1'b0);
    chk({tag, "_align_state"}, st, 2);
    chk({tag, "_align_lect"}, lect, 1);
    for (int c = 2; c <= 4; c++) begin
      strobes(9);
      cyc(1'b0, 1'b1, 1'b0);
      chk({tag, "_comma_state"}, st, (c == 4) ? 3 : 2);
    end
    chk({tag, "_link_up"}, lup, 1);
    chk({tag, "_lect"}, lect, 1);
  endtask

  initial begin
    #3 rst = 1'b0;
    #1;
    chk("rst_state", st, 0);
    chk("rst_lect", lect, 0);
    chk("rst_link_up", lup, 0);
    chk("rst_lock_lost", llost, 0);
    chk("rst_err_total", etot, 0);
    enb = 1'b1;
    #10 rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("search_state", st, 1);
    chk("search_lect", lect, 0);

    do_lock("lock1");

    // Five windows of three errors each; the last one lands on the wrap strobe.
    for (int w = 1; w <= 5; w++) begin
      for (int p = 1; p <= 16; p++)
        cyc(1'b1, 1'b0, (p == 4) || (p == 8) || (w < 5 ? (p == 12) : (p == 16)));
      cyc(1'b0, 1'b1, 1'b0);
      chk("win_state", st, 3);
      chk("win_lock_lost", llost, 0);
    end
    chk("win_err_total", etot, 15);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("carry_still_locked", st, 3);
    cyc(1'b1, 1'b0, 1'b1);
    chk("carry_state", st, 1);
    chk("carry_lock_lost", llost, 1);
    chk("carry_link_up", lup, 0);
    chk("carry_lect", lect, 0);
    chk("carry_err_total", etot, 18);
    cyc(1'b0, 1'b0, 1'b0);
    chk("carry_pulse_end", llost, 0);

    // Alignment timeout after two commas.
    cyc(1'b0, 1'b1, 1'b0);
    strobes(9);
    cyc(1'b0, 1'b1, 1'b0);
    strobes(63);
    chk("to_pre_state", st, 2);
    strobes(1);
    chk("to_state", st, 1);
    chk("to_lect", lect, 0);
    chk("to_lock_lost", llost, 0);
    // Comma beats a simultaneous timeout; count restarts so four fresh commas are needed.
    cyc(1'b0, 1'b1, 1'b0);
    strobes(63);
    cyc(1'b1, 1'b1, 1'b0);
    chk("tie_state", st, 2);
    strobes(9);
    cyc(1'b0, 1'b1, 1'b0);
    chk("restart_third_state", st, 2);
    strobes(9);
    cyc(1'b0, 1'b1, 1'b0);
    chk("restart_lock_state", st, 3);

    // Asynchronous reset between clock edges while locked.
    #2 rst = 1'b0;
    #1;
    chk("arst_state", st, 0);
    chk("arst_link_up", lup, 0);
    chk("arst_lect", lect, 0);
    chk("arst_err_total", etot, 0);
    #1 rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("arst_release_state", st, 1);

    // Four errors within one window.
    do_lock("lock2");
    for (int p = 1; p <= 7; p++) cyc(1'b1, 1'b0, (p % 2) == 0);
    chk("thr_pre_state", st, 3);
    cyc(1'b1, 1'b0, 1'b1);
    chk("thr_state", st, 1);
    chk("thr_lock_lost", llost, 1);
    chk("thr_err_total", etot, 4);
    cyc(1'b0, 1'b0, 1'b0);
    chk("thr_pulse_end", llost, 0);

    // Disable while locked, then relock.
    do_lock("lock3");
    cyc(1'b0, 1'b0, 1'b1);
    chk("err_no_strobe", etot, 4);
    cyc(1'b1, 1'b0, 1'b1);
    chk("err_strobe", etot, 5);
    enb = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("dis_state", st, 0);
    chk("dis_link_up", lup, 0);
    chk("dis_lect", lect, 0);
    chk("dis_err_total", etot, 5);
    enb = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("reen_state", st, 1);
    do_lock("lock4");

    // Comma starvation while locked.
    strobes(63);
    chk("gap_pre_state", st, 3);
    strobes(1);
    chk("gap_state", st, 1);
    chk("gap_lock_lost", llost, 1);
    chk("gap_err_total", etot, 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, got running expected finished");
    $fatal(1);
  end

endmodule
